buffered_uart_tx: RTL
=====================

Name: buffered_uart_tx

Overview:
- Buffered UART transmitter between the SoC UART_TX register write path and the serial pin.
- CPU writes are pushed into a FIFO; an internal serializer drains it with 8N1-style framing at a programmable bit period.
- Writes are non-blocking while the FIFO has room.
- Level, empty and busy outputs feed the SoC's UART LSR read data.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
DATA_BITS, 8, data bits per frame, LSB first
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
wr_valid  input  1  push request
wr_data  input  DATA_BITS  byte to push
wr_ready  output  1  push accepted this cycle; combinational, equal to !full
div  input  16  bit period in clk cycles; value 0 is treated as 1
ovf_clr  input  1  clears the overflow flag
tx_out  output  1  serial line, idle high
level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
empty  output  1  level == 0
full  output  1  level == DEPTH
busy  output  1  !empty or serializer not IDLE
tx_done  output  1  one-cycle pulse at the end of the last stop bit of each frame
overflow  output  1  sticky; set on wr_valid && full

Behaviour:
- Reset (rst_n low at a clk edge):
  - tx_out=1, level=0, empty=1, full=0, busy=0, tx_done=0, overflow=0; FSM to IDLE.
  - FIFO pointers cleared; contents are don't-care.
  - Reset mid-frame aborts the frame; tx_out is high from the next edge.
- FIFO:
  - Circular buffer, read/write pointers $clog2(DEPTH) bits wide, wrapping modulo DEPTH.
  - level is a separate counter.
  - Push when wr_valid && !full. Pop is internal only.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle; wr_ready stays purely !full.
  - overflow clears when ovf_clr=1. If set and clear coincide, set wins.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - bit_cnt counts cycles within a bit, 0..period-1.
  - idx counts data or stop bits.
  - period is latched from div at pop (div==0 gives 1); changes to div mid-frame have no effect.
- IDLE:
  - tx_out=1.
  - If !empty: pop at this edge, latch the byte and period, go to START.
  - The start bit drives from the cycle after the pop edge. A byte pushed at edge N into an empty, idle block is popped at edge N+1.
- START: tx_out=0 for period cycles, then DATA.
- DATA:
  - tx_out = shift[idx], idx 0..DATA_BITS-1, each bit held for period cycles.
  - Then STOP.
- STOP:
  - tx_out=1 for STOP_BITS*period cycles.
  - On the final cycle, tx_done pulses.
  - At that edge: if !empty, pop and go directly to START (no idle gap between frames); else go to IDLE.
- Frame length is exactly (1+DATA_BITS+STOP_BITS)*period cycles. Back-to-back frames are contiguous.
- level counts only unpopped entries; the byte being shifted is not included.
- busy is combinational from level and state.

Test Plan:
1. Reset, div=4, push 0xA5 at edge N. Required:
   - level=1 after N; popped at N+1, level=0.
   - tx_out low for cycles N+1..N+4.
   - Data bits 1,0,1,0,0,1,0,1 for 4 cycles each.
   - Stop high 4 cycles; tx_done pulses once.
   - Total 40 cycles; busy falls after tx_done.
2. div=1, push 0x00,0xFF,0x55 on consecutive cycles. Required:
   - Three contiguous 10-cycle frames with no idle cycle between them.
   - Exactly 3 tx_done pulses.
   - level peaks at 2.
3. div=100, push 17 bytes while the first is still shifting. Required:
   - After the pop, level reaches 16, full=1, wr_ready=0.
   - The 18th push is dropped and overflow=1.
   - ovf_clr clears overflow.
   - All 17 accepted bytes appear on tx_out in order.
4. Full FIFO, wr_valid held high across the pop edge. Required:
   - The push in the pop cycle is rejected.
   - Push succeeds the next cycle; level returns to 16.
5. div=0. Required: behaves as period 1, 10-cycle frame.
6. Mid-frame (DATA bit 3) assert rst_n=0 for one edge. Required:
   - tx_out=1, level=0, busy=0 from the next edge.
   - A subsequent push of 0x3C transmits correctly.

Source files
------------

// File: rtl/buffered_uart_tx.sv
// Buffered UART transmitter: CPU-side FIFO drained by an 8N1-style serializer
// with a per-frame programmable bit period.
module buffered_uart_tx #(
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [DATA_BITS-1:0]     wr_data,
  output logic                     wr_ready,
  input  logic [15:0]              div,
  input  logic                     ovf_clr,
  output logic                     tx_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     busy,
  output logic                     tx_done,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int IMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int IW   = $clog2(IMAX + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic                 overflow_q;

  state_t               state_q, state_d;
  logic [15:0]          bit_cnt_q, bit_cnt_d;
  logic [15:0]          period_q, period_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  logic push, pop, bit_end;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign wr_ready = !full;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign busy     = !empty || (state_q != IDLE);
  assign push     = wr_valid && !full;
  assign bit_end  = (bit_cnt_q == period_q - 16'd1);

  // NOTE: the storage array has no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      // A dropped write wins over a simultaneous clear so no overflow is ever lost.
      if (wr_valid && full) overflow_q <= 1'b1;
      else if (ovf_clr)     overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      period_q  <= 16'd1;
      idx_q     <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      period_q  <= period_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 16'd1;
    period_d  = period_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_done   = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = mem[rd_ptr_q];
          period_d = (div == 16'd0) ? 16'd1 : div;
          idx_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          // The current bit always sits in shift_q[0]; shifting walks idx through the byte.
          shift_d   = shift_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (idx_q == IW'(STOP_BITS - 1)) begin
            tx_done = 1'b1;
            idx_d   = '0;
            if (!empty) begin
              pop      = 1'b1;
              shift_d  = mem[rd_ptr_q];
              period_d = (div == 16'd0) ? 16'd1 : div;
              state_d  = START;
            end else begin
              state_d  = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      default: tx_out = 1'b1;
    endcase
  end

endmodule
